// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register block.
package apb_pkg;

  // Per-register access mode; 2'd3 is unused and behaves like RO.
  typedef enum logic [1:0] {
    RO  = 2'd0,
    RW  = 2'd1,
    W1C = 2'd2
  } reg_mode_e;

  // pslverr_o encodings.
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_reg_cell.sv
// One register slot: byte-strobe merge for RW, write-one-to-clear with
// sticky hardware set for W1C, pass-through of an external value for RO.
module apb_reg_cell
  import apb_pkg::*;
#(
  parameter reg_mode_e                Mode         = RW,
  parameter int unsigned              RegDataWidth = 32,
  parameter logic [RegDataWidth-1:0]  RstVal       = '0,
  localparam int unsigned             StrbWidth    = (RegDataWidth + 7) / 8
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic                    wr_en_i,
  input  logic [RegDataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0]    wstrb_i,
  input  logic [RegDataWidth-1:0] hw_set_i,
  input  logic [RegDataWidth-1:0] ro_val_i,
  output logic [RegDataWidth-1:0] q_o
);

  logic [RegDataWidth-1:0] bit_mask;

  // Expand byte strobes into a per-bit write mask.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    bit_mask = '0;
    for (int k = 0; k < int'(RegDataWidth); k++) begin
      bit_mask[k] = wstrb_i[k / 8];
    end
  end

  if (Mode == RW) begin : g_rw
    logic unused_rw;
    assign unused_rw = ^{hw_set_i, ro_val_i};

    // Merge written bytes into the stored value on commit.
    always_ff @(posedge pclk_i or posedge preset_i) begin
      // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
      if (preset_i) begin
        q_o <= RstVal;
      end else if (wr_en_i) begin
        q_o <= (q_o & ~bit_mask) | (wdata_i & bit_mask);
      end
    end
  end else if (Mode == W1C) begin : g_w1c
    logic                    unused_w1c;
    logic [RegDataWidth-1:0] clr_bits;
    assign unused_w1c = ^ro_val_i;
    assign clr_bits   = wr_en_i ? (wdata_i & bit_mask) : '0;

    // Clear written ones, then OR in hardware sets so a same-cycle set wins.
    always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
        q_o <= RstVal;
      end else begin
        q_o <= (q_o & ~clr_bits) | hw_set_i;
      end
    end
  end else begin : g_ro
    logic unused_ro;
    assign unused_ro = ^{pclk_i, preset_i, wr_en_i, wdata_i, hw_set_i, bit_mask};

    // Read-only slots hold no state and mirror the external value.
    assign q_o = ro_val_i;
  end

endmodule

// File: rtl/apb_regs_rwc.sv
// APB slave exposing NoApbRegs registers with RO / RW / W1C modes and
// an optional fixed number of access-phase wait states.
module apb_regs_rwc
  import apb_pkg::*;
#(
  parameter int unsigned                             NoApbRegs    = 16,
  parameter int unsigned                             ApbAddrWidth = 32,
  parameter int unsigned                             ApbDataWidth = 32,
  localparam int unsigned                            ApbStrbWidth = (ApbDataWidth + 7) / 8,
  parameter int unsigned                             RegDataWidth = 32,
  parameter int unsigned                             WaitCycles   = 0,
  parameter logic [NoApbRegs-1:0][1:0]               RegMode      = {NoApbRegs{RW}},
  parameter logic [NoApbRegs-1:0][RegDataWidth-1:0]  RegRstVal    = '0
) (
  input  logic                                   pclk_i,
  input  logic                                   preset_i,
  input  logic                                   psel_i,
  input  logic                                   penable_i,
  input  logic                                   pwrite_i,
  input  logic [ApbAddrWidth-1:0]                paddr_i,
  input  logic [ApbDataWidth-1:0]                pwdata_i,
  input  logic [ApbStrbWidth-1:0]                pstrb_i,
  output logic                                   pready_o,
  output logic                                   pslverr_o,
  output logic [ApbDataWidth-1:0]                prdata_o,
  input  logic [ApbAddrWidth-1:0]                base_addr_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_ro_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] hw_set_i,
  output logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_q_o
);

  localparam int unsigned IdxW     = (NoApbRegs > 1) ? $clog2(NoApbRegs) : 1;
  localparam int unsigned CntW     = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
  localparam int unsigned RegStrbW = (RegDataWidth + 7) / 8;

  if (RegDataWidth > ApbDataWidth) begin : g_width_check
    $error("apb_regs_rwc: RegDataWidth must not exceed ApbDataWidth");
  end

  logic [ApbAddrWidth-1:0] offset;
  logic [ApbAddrWidth-1:0] idx_full;
  logic [IdxW-1:0]         idx;
  logic                    in_range;
  logic                    access;
  logic                    slot_writable;
  logic                    err;
  logic [CntW-1:0]         wait_cnt;
  reg_mode_e               sel_mode;

  // Modular offset from the base; the two byte-lane address bits drop out.
  assign offset   = paddr_i - base_addr_i;
  assign idx_full = offset >> 2;
  assign idx      = idx_full[IdxW-1:0];
  assign in_range = idx_full < ApbAddrWidth'(NoApbRegs);
  assign sel_mode = reg_mode_e'(RegMode[idx]);

  assign slot_writable = (sel_mode == RW) || (sel_mode == W1C);
  assign err           = !in_range || (pwrite_i && !slot_writable);
  assign access        = psel_i && penable_i;

  // Holding pready_o low in reset also keeps pslverr_o and prdata_o at zero.
  assign pready_o  = access && (wait_cnt == CntW'(WaitCycles)) && !preset_i;
  assign pslverr_o = pready_o ? err : RESP_OKAY;
  assign prdata_o  = (pready_o && !pwrite_i && !err) ? ApbDataWidth'(reg_q_o[idx]) : '0;

  // Count access-phase cycles; any break in psel/penable discards progress.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      wait_cnt <= '0;
    end else if (!access || pready_o) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < int'(NoApbRegs); i++) begin : g_reg
    logic wr_en;
    assign wr_en = pready_o && pwrite_i && !err && (idx == IdxW'(i));

    apb_reg_cell #(
      .Mode         (reg_mode_e'(RegMode[i])),
      .RegDataWidth (RegDataWidth),
      .RstVal       (RegRstVal[i])
    ) u_cell (
      .pclk_i   (pclk_i),
      .preset_i (preset_i),
      .wr_en_i  (wr_en),
      .wdata_i  (pwdata_i[RegDataWidth-1:0]),
      .wstrb_i  (pstrb_i[RegStrbW-1:0]),
      .hw_set_i (hw_set_i[i]),
      .ro_val_i (reg_ro_i[i]),
      .q_o      (reg_q_o[i])
    );
  end

endmodule
